// File: rtl/thermal_pkg.sv
// Shared types for the multi-channel thermal monitor: channel states, sample
// zones and the 2-bit status encoding presented on the status bus.
package thermal_pkg;

    localparam int CNT_W = 4;

    localparam logic [1:0] STAT_NORMAL = 2'b00;
    localparam logic [1:0] STAT_WARN   = 2'b01;
    localparam logic [1:0] STAT_TRIP   = 2'b10;

    typedef enum logic [1:0] {
        ST_NORMAL = 2'b00,
        ST_WARN   = 2'b01,
        ST_TRIP   = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        Z_NORMAL,
        Z_WARN,
        Z_TRIP
    } zone_t;

    function automatic logic [1:0] status_code(input state_t s);
        case (s)
            ST_WARN: return STAT_WARN;
            ST_TRIP: return STAT_TRIP;
            default: return STAT_NORMAL;
        endcase
    endfunction

endpackage

// File: rtl/thermal_channel.sv
// One sensor channel: zone classification, debounced NORMAL/WARN/TRIP FSM with
// hysteresis on descent, and a software-released trip latch.
module thermal_channel
    import thermal_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int WARN_TH  = 192,
    parameter int TRIP_TH  = 240,
    parameter int HYST     = 8,
    parameter int DEBOUNCE = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_valid,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_reading,
    output state_t           o_state,
    output logic             o_enter_trip,
    output logic             o_trip_nxt
);

    localparam logic [WIDTH-1:0] L_WARN    = WIDTH'(WARN_TH);
    localparam logic [WIDTH-1:0] L_TRIP    = WIDTH'(TRIP_TH);
    localparam logic [WIDTH-1:0] L_WARN_LO = WIDTH'(WARN_TH - HYST);
    localparam logic [WIDTH-1:0] L_TRIP_LO = WIDTH'(TRIP_TH - HYST);
    localparam logic [CNT_W-1:0] L_DEB     = CNT_W'(DEBOUNCE);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_run;
    logic             r_dir, w_dir_nxt;
    zone_t            w_zone;
    logic             w_up, w_below;

    always_comb begin
        if (i_reading > L_TRIP)
            w_zone = Z_TRIP;
        else if (i_reading >= L_WARN)
            w_zone = Z_WARN;
        else
            w_zone = Z_NORMAL;
    end

    assign w_up    = (w_zone == Z_TRIP);
    assign w_below = (i_reading < L_WARN_LO);
    // In WARN a reversal of direction restarts the run at one sample.
    assign w_run   = (r_dir == w_up) ? r_cnt + CNT_W'(1) : CNT_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dir_nxt   = r_dir;
        case (r_state)
            ST_NORMAL: begin
                if (i_valid) begin
                    if (w_zone != Z_NORMAL) begin
                        if (r_cnt + CNT_W'(1) == L_DEB) begin
                            w_state_nxt = w_up ? ST_TRIP : ST_WARN;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                            w_dir_nxt = 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = '0;
                    end
                end
            end
            ST_WARN: begin
                if (i_valid) begin
                    if (w_up || w_below) begin
                        if (w_run == L_DEB) begin
                            w_state_nxt = w_up ? ST_TRIP : ST_NORMAL;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = w_run;
                            w_dir_nxt = w_up;
                        end
                    end else begin
                        w_cnt_nxt = '0;
                    end
                end
            end
            ST_TRIP: begin
                // Release only against a same-cycle valid reading clear of the trip band.
                if (i_valid && i_clear && (i_reading <= L_TRIP_LO)) begin
                    w_state_nxt = ST_WARN;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_NORMAL;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_NORMAL;
            r_cnt   <= '0;
            r_dir   <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dir   <= w_dir_nxt;
        end
    end

    assign o_state      = r_state;
    assign o_trip_nxt   = (w_state_nxt == ST_TRIP);
    assign o_enter_trip = (w_state_nxt == ST_TRIP) && (r_state != ST_TRIP);

endmodule

// File: rtl/thermal_monitor.sv
// Multi-channel over-temperature monitor: per-channel FSMs, system alarm and
// shutdown reductions, and capture of the first channel to trip.
module thermal_monitor
    import thermal_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int WARN_TH  = 192,
    parameter int TRIP_TH  = 240,
    parameter int HYST     = 8,
    parameter int DEBOUNCE = 3,
    localparam int FT_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [CHANNELS*WIDTH-1:0] reading,
    input  logic [CHANNELS-1:0]       valid,
    input  logic [CHANNELS-1:0]       clear_trip,
    output logic [2*CHANNELS-1:0]     status,
    output logic                      alarm,
    output logic                      shut_down,
    output logic [FT_W-1:0]           first_trip,
    output logic                      first_trip_vld
);

    if (HYST > WARN_TH || WARN_TH > TRIP_TH || TRIP_TH >= 2**WIDTH - 1 ||
        DEBOUNCE < 1 || DEBOUNCE > 15) begin : g_bad_params
        $error("thermal_monitor: illegal threshold/debounce parameters");
    end

    state_t [CHANNELS-1:0] w_state;
    logic   [CHANNELS-1:0] w_enter, w_trip_nxt, w_trip, w_busy;
    logic   [FT_W-1:0]     w_first_idx, r_first;
    logic                  r_first_vld;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        thermal_channel #(
            .WIDTH    (WIDTH),
            .WARN_TH  (WARN_TH),
            .TRIP_TH  (TRIP_TH),
            .HYST     (HYST),
            .DEBOUNCE (DEBOUNCE)
        ) u_ch (
            .clk          (clk),
            .reset_n      (reset_n),
            .i_valid      (valid[i]),
            .i_clear      (clear_trip[i]),
            .i_reading    (reading[i*WIDTH +: WIDTH]),
            .o_state      (w_state[i]),
            .o_enter_trip (w_enter[i]),
            .o_trip_nxt   (w_trip_nxt[i])
        );
        assign status[2*i +: 2] = status_code(w_state[i]);
        assign w_trip[i]        = (w_state[i] == ST_TRIP);
        assign w_busy[i]        = (w_state[i] != ST_NORMAL);
    end

    assign alarm     = |w_busy;
    assign shut_down = |w_trip;

    // Lowest index wins when several channels enter TRIP on the same edge.
    always_comb begin
        w_first_idx = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (w_enter[i])
                w_first_idx = FT_W'(i);
        end
    end

    // Valid drops on the edge after which no channel remains in TRIP; the index is kept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_first     <= '0;
            r_first_vld <= 1'b0;
        end else if (!r_first_vld) begin
            if (|w_enter) begin
                r_first     <= w_first_idx;
                r_first_vld <= 1'b1;
            end
        end else if (!(|w_trip_nxt)) begin
            r_first_vld <= 1'b0;
        end
    end

    assign first_trip     = r_first;
    assign first_trip_vld = r_first_vld;

endmodule
